// File: rtl/reaction_timer_pkg.sv
// Shared types and constants for the multi-player reaction timer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package reaction_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } rt_state_t;

  // Non-zero seed so the Fibonacci LFSR never locks up at all-zeros.
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Taps 16,14,13,11 expressed as bit positions 15,13,12,10.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic lfsr_fb(input logic [15:0] q);
    return ^(q & LFSR_TAPS);
  endfunction

endpackage

// File: rtl/rt_lfsr16.sv
// 16-bit Fibonacci LFSR used to randomise the pre-stimulus delay.
// Latency: new value one cycle after each enabled clock.
// Backpressure: none; en low holds the current value.
module rt_lfsr16
  import reaction_timer_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic [15:0] q
);

  // Shift left, feeding the tap parity into bit 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= LFSR_SEED;
    end else if (en) begin
      q <= {q[14:0], lfsr_fb(q)};
    end
  end

endmodule

// File: rtl/reaction_timer_mp.sv
// Multi-player reaction timer: random delay, LED stimulus, first valid press wins.
// Latency: result registered one cycle after the winning press edge.
// Backpressure: none; ena low freezes every register, start ignored while busy.
module reaction_timer_mp
  import reaction_timer_pkg::*;
#(
  parameter int N_PLAYERS  = 4,
  parameter int CNT_W      = 12,
  parameter int PRESCALE   = 10000,
  parameter int DELAY_MIN  = 500,
  parameter int DELAY_BITS = 10
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         ena,
  input  logic                         start,
  input  logic [N_PLAYERS-1:0]         btn,
  output logic                         led_on,
  output logic                         busy,
  output logic                         done,
  output logic [$clog2(N_PLAYERS)-1:0] winner,
  output logic                         win_valid,
  output logic [CNT_W-1:0]             time_out,
  output logic [N_PLAYERS-1:0]         false_start
);

  localparam int WIN_W = $clog2(N_PLAYERS);
  localparam int PSC_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PSC_W-1:0] PSC_MAX = PSC_W'(PRESCALE - 1);
  localparam int DLY_W = $clog2(DELAY_MIN + (1 << DELAY_BITS) + 1);
  localparam logic [15:0] DLY_MASK =
    (DELAY_BITS == 0) ? 16'h0 : 16'((32'd1 << DELAY_BITS) - 32'd1);
  localparam logic [DLY_W-1:0] DLY_BASE = DLY_W'(DELAY_MIN);

  rt_state_t            state_q, state_d;
  logic [PSC_W-1:0]     psc_q;
  logic [DLY_W-1:0]     dly_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [N_PLAYERS-1:0] btn_q;
  logic [15:0]          lfsr_q;

  logic                 tick;
  logic [N_PLAYERS-1:0] press;
  logic [N_PLAYERS-1:0] elig;
  logic [N_PLAYERS-1:0] flag_set;
  logic [WIN_W-1:0]     win_idx;
  logic                 load_round;
  logic                 go_run;
  logic                 win_hit;
  logic                 tmo_hit;
  logic [DLY_W-1:0]     dly_load;

  rt_lfsr16 u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (ena),
    .q     (lfsr_q)
  );

  assign tick     = (psc_q == PSC_MAX);
  assign press    = btn & ~btn_q;
  assign dly_load = DLY_BASE + DLY_W'(lfsr_q & DLY_MASK);
  assign led_on   = (state_q == ST_RUN);
  assign busy     = (state_q == ST_WAIT) || (state_q == ST_RUN);
  assign done     = (state_q == ST_DONE);

  // State register; reset forces IDLE immediately, which drops led_on/busy/done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else if (ena) begin
      state_q <= state_d;
    end
  end

  // Next-state and per-cycle round events.
  always_comb begin
    state_d    = state_q;
    load_round = 1'b0;
    go_run     = 1'b0;
    win_hit    = 1'b0;
    tmo_hit    = 1'b0;
    flag_set   = '0;
    win_idx    = '0;
    elig       = press & ~false_start;
    // Scan high to low so the lowest simultaneous index wins.
    for (int i = N_PLAYERS - 1; i >= 0; i--) begin
      if (elig[i]) win_idx = WIN_W'(i);
    end
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d    = ST_WAIT;
          load_round = 1'b1;
        end
      end
      ST_WAIT: begin
        flag_set = press;
        // Everyone disqualified ends the round even on the delay's last tick.
        if (&(false_start | press)) begin
          state_d = ST_DONE;
        end else if (tick && (dly_q <= DLY_W'(1))) begin
          state_d = ST_RUN;
          go_run  = 1'b1;
        end
      end
      ST_RUN: begin
        if (|elig) begin
          state_d = ST_DONE;
          win_hit = 1'b1;
        end else if (&cnt_q) begin
          state_d = ST_DONE;
          tmo_hit = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Prescaler, delay, reaction counter and edge history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      psc_q <= '0;
      dly_q <= '0;
      cnt_q <= '0;
      btn_q <= '0;
    end else if (ena) begin
      btn_q <= btn;
      if (load_round || go_run || tick) begin
        psc_q <= '0;
      end else begin
        psc_q <= psc_q + PSC_W'(1);
      end
      if (load_round) begin
        dly_q <= dly_load;
      end else if ((state_q == ST_WAIT) && tick && (dly_q != '0)) begin
        dly_q <= dly_q - DLY_W'(1);
      end
      if (go_run) begin
        cnt_q <= '0;
      end else if ((state_q == ST_RUN) && tick && !(&cnt_q)) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  // Result registers: cleared at round start, latched on win or timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      false_start <= '0;
      winner      <= '0;
      time_out    <= '0;
      win_valid   <= 1'b0;
    end else if (ena) begin
      if (load_round) begin
        false_start <= '0;
        winner      <= '0;
        time_out    <= '0;
        win_valid   <= 1'b0;
      end else begin
        false_start <= false_start | flag_set;
        if (win_hit) begin
          winner    <= win_idx;
          time_out  <= cnt_q;
          win_valid <= 1'b1;
        end else if (tmo_hit) begin
          time_out  <= '1;
          win_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_reaction_timer_mp.sv
// Bench for reaction_timer_mp with small parameters and a cycle-count model.
// Latency: n/a.
// Backpressure: n/a.
module tb_reaction_timer_mp;

  localparam int NP   = 4;
  localparam int CW   = 8;
  localparam int PS   = 1;
  localparam int DMIN = 5;
  localparam int DB   = 0;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b1;
  logic          ena   = 1'b1;
  logic          start = 1'b0;
  logic [NP-1:0] btn   = '0;
  logic          led_on, busy, done, win_valid;
  logic [1:0]    winner;
  logic [CW-1:0] time_out;
  logic [NP-1:0] false_start;

  int n_cmp   = 0;
  int n_bad   = 0;
  int led_cnt = 0;

  reaction_timer_mp #(
    .N_PLAYERS (NP),
    .CNT_W     (CW),
    .PRESCALE  (PS),
    .DELAY_MIN (DMIN),
    .DELAY_BITS(DB)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .start      (start),
    .btn        (btn),
    .led_on     (led_on),
    .busy       (busy),
    .done       (done),
    .winner     (winner),
    .win_valid  (win_valid),
    .time_out   (time_out),
    .false_start(false_start)
  );

  always #5 clk = ~clk;

  // Model: phase 0 idle, 1 waiting, 2 LED lit, 3 finished; timing kept as
  // counts of enabled cycles rather than ticks.
  int         m_phase     = 0;
  int         m_wait_left = 0;
  int         m_run_cyc   = 0;
  int         m_win       = 0;
  int         m_to        = 0;
  bit         m_wv        = 1'b0;
  logic [3:0] m_fs        = '0;
  logic [3:0] m_prev      = '0;

  function automatic int lowest(input logic [3:0] v);
    int r;
    r = 0;
    for (int i = 3; i >= 0; i--) if (v[i]) r = i;
    return r;
  endfunction

  // Behavioural model, advanced once per enabled clock.
  always @(posedge clk or negedge rst_n) begin
    logic [3:0] rises;
    logic [3:0] elig;
    int         ticks;
    if (!rst_n) begin
      m_phase = 0; m_wait_left = 0; m_run_cyc = 0;
      m_win = 0; m_to = 0; m_wv = 1'b0; m_fs = '0; m_prev = '0;
    end else if (ena) begin
      rises  = btn & ~m_prev;
      m_prev = btn;
      case (m_phase)
        0, 3: begin
          if (start) begin
            m_phase = 1; m_wait_left = DMIN * PS;
            m_fs = '0; m_wv = 1'b0; m_to = 0; m_win = 0;
          end
        end
        1: begin
          m_fs = m_fs | rises;
          if (m_fs == 4'hF) begin
            m_phase = 3;
          end else begin
            m_wait_left = m_wait_left - 1;
            if (m_wait_left == 0) begin
              m_phase = 2; m_run_cyc = 0;
            end
          end
        end
        2: begin
          ticks = m_run_cyc / PS;
          elig  = rises & ~m_fs;
          if (elig != 0) begin
            m_win = lowest(elig); m_to = ticks; m_wv = 1'b1; m_phase = 3;
          end else if (ticks == 255) begin
            m_to = 255; m_phase = 3;
          end else begin
            m_run_cyc = m_run_cyc + 1;
          end
        end
        default: m_phase = 0;
      endcase
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_loop();
    forever begin
      @(negedge clk);
      if (led_on) led_cnt++;
      chk("led_on",      32'(led_on),      32'(m_phase == 2));
      chk("busy",        32'(busy),        32'(m_phase == 1 || m_phase == 2));
      chk("done",        32'(done),        32'(m_phase == 3));
      chk("win_valid",   32'(win_valid),   32'(m_wv));
      chk("winner",      32'(winner),      32'(m_win));
      chk("time_out",    32'(time_out),    32'(m_to));
      chk("false_start", 32'(false_start), 32'(m_fs));
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic begin_round();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic wait_led(output int k);
    k = 0;
    while (!led_on && k < 100) begin
      cyc();
      k++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1);
  end

  initial begin
    int k, k2, l0;
    fork
      compare_loop();
    join_none
    #1 rst_n = 1'b0;
    repeat (3) cyc();
    chk("rst led_on",      32'(led_on),      32'd0);
    chk("rst busy",        32'(busy),        32'd0);
    chk("rst done",        32'(done),        32'd0);
    chk("rst false_start", 32'(false_start), 32'd0);
    chk("rst time_out",    32'(time_out),    32'd0);
    rst_n = 1'b1;
    cyc();

    // Single winner three ticks after the LED.
    begin_round();
    wait_led(k);
    chk("s1 delay cycles", k, 5);
    repeat (3) cyc();
    btn = 4'b0100;
    cyc();
    btn = '0;
    chk("s1 winner",    32'(winner),    32'd2);
    chk("s1 time_out",  32'(time_out),  32'd3);
    chk("s1 win_valid", 32'(win_valid), 32'd1);
    chk("s1 done",      32'(done),      32'd1);

    // Flagged player 1 ignored when pressing together with player 3.
    begin_round();
    btn = 4'b0010;
    cyc();
    btn = '0;
    wait_led(k);
    btn = 4'b1010;
    cyc();
    btn = '0;
    chk("s2 false_start", 32'(false_start), 32'b0010);
    chk("s2 winner",      32'(winner),      32'd3);
    chk("s2 win_valid",   32'(win_valid),   32'd1);

    // Start while busy is ignored; tie goes to lowest index.
    begin_round();
    start = 1'b1;
    cyc();
    start = 1'b0;
    wait_led(k);
    chk("s3 delay after busy start", k, 4);
    cyc();
    btn = 4'b0101;
    cyc();
    btn = '0;
    chk("s3 winner",   32'(winner),   32'd0);
    chk("s3 time_out", 32'(time_out), 32'd1);

    // No press: timeout at all-ones.
    begin_round();
    wait_led(k);
    k = 0;
    while (!done && k < 400) begin
      cyc();
      k++;
    end
    chk("s4 lit cycles", k, 256);
    chk("s4 time_out",  32'(time_out),  32'hFF);
    chk("s4 win_valid", 32'(win_valid), 32'd0);
    chk("s4 done",      32'(done),      32'd1);

    // Everyone jumps the gun.
    l0 = led_cnt;
    begin_round();
    btn = 4'hF;
    cyc();
    btn = '0;
    repeat (3) cyc();
    chk("s5 done",        32'(done),        32'd1);
    chk("s5 false_start", 32'(false_start), 32'hF);
    chk("s5 win_valid",   32'(win_valid),   32'd0);
    chk("s5 led cycles",  led_cnt - l0,     0);

    // Enable freeze stretches the delay, then reset mid-RUN.
    begin_round();
    cyc();
    cyc();
    ena = 1'b0;
    repeat (10) cyc();
    ena = 1'b1;
    wait_led(k2);
    chk("s6 stretch", 2 + 10 + k2 - DMIN, 10);
    cyc();
    cyc();
    rst_n = 1'b0;
    #1;
    chk("s6 rst led_on", 32'(led_on), 32'd0);
    chk("s6 rst busy",   32'(busy),   32'd0);
    chk("s6 rst done",   32'(done),   32'd0);
    cyc();
    rst_n = 1'b1;
    cyc();
    chk("s6 idle busy", 32'(busy), 32'd0);
    repeat (2) cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/reaction_timer_mp.md
REACTION_TIMER_MP -- requirements
Module: reaction_timer_mp

Interface
REQ-001 SHALL have parameter N_PLAYERS, default 4, number of button channels (2..8).
REQ-002 SHALL have parameter CNT_W, default 12, reaction-time counter width in ticks.
REQ-003 SHALL have parameter PRESCALE, default 10000, clk cycles per tick (1 ms at 10 MHz); minimum 1.
REQ-004 SHALL have parameter DELAY_MIN, default 500, minimum random delay in ticks.
REQ-005 SHALL have parameter DELAY_BITS, default 10, LFSR bits added to DELAY_MIN; 0 means fixed delay.
REQ-006 SHALL have port clk, input, 1, system clock.
REQ-007 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port ena, input, 1, global enable; low freezes all state.
REQ-009 SHALL have port start, input, 1, round start request, level-sampled.
REQ-010 SHALL have port btn, input, N_PLAYERS, player buttons, synchronous and debounced upstream.
REQ-011 SHALL have port led_on, output, 1, stimulus LED.
REQ-012 SHALL have port busy, output, 1, round in progress.
REQ-013 SHALL have port done, output, 1, result valid.
REQ-014 SHALL have port winner, output, clog2(N_PLAYERS), winning player index.
REQ-015 SHALL have port win_valid, output, 1, winner and time_out are meaningful.
REQ-016 SHALL have port time_out, output, CNT_W, winner reaction time in ticks.
REQ-017 SHALL have port false_start, output, N_PLAYERS, per-player disqualification flags.

Function
REQ-018 SHALL detect button presses as rising edges (btn high, previous-cycle btn low), per player.
REQ-019 SHALL implement FSM IDLE, WAIT, RUN, DONE.
REQ-020 SHALL advance IDLE or DONE to WAIT when start=1 — clearing false_start, done, win_valid, time_out and winner, and loading delay = DELAY_MIN + lfsr[DELAY_BITS-1:0].
REQ-021 SHALL generate a tick every PRESCALE enabled cycles; the prescaler SHALL clear on entry to WAIT and to RUN.
REQ-022 SHALL decrement the delay per tick in WAIT, and enter RUN on the tick where the delay reaches 0.
REQ-023 SHALL set false_start[i] on a press by player i in WAIT; the flag is sticky until the next start.
REQ-024 SHALL enter DONE with win_valid=0 when every player is flagged in WAIT.
REQ-025 SHALL hold led_on=1 only in RUN, with the counter cleared on RUN entry and incremented per tick.
REQ-026 SHALL latch winner and time_out on the first RUN press from an unflagged player, then set win_valid=1 and enter DONE.
REQ-027 SHALL award simultaneous same-cycle presses to the lowest index.
REQ-028 SHALL ignore presses from flagged players in RUN.
REQ-029 SHALL treat a counter of all-ones (2^CNT_W-1) as timeout: DONE with win_valid=0 and time_out all-ones.
REQ-030 SHALL assert busy in WAIT and RUN, assert done only in DONE, and ignore start while busy.
REQ-031 SHALL freeze FSM, prescaler, counters, LFSR and edge-detect registers while ena=0.
REQ-032 SHALL advance a 16-bit Fibonacci LFSR (taps 16,14,13,11) every enabled cycle; it never reaches 0.

Reset
REQ-033 SHALL, on rst_n low at any time including mid-round, asynchronously force IDLE and set all outputs to 0.
REQ-034 SHALL reset the prescaler, counters and edge registers to 0, and the LFSR to 16'hACE1.

Structure
REQ-035 SHALL import the FSM state enum, LFSR seed and tap mask from package reaction_timer_pkg.
REQ-036 SHALL instantiate one sub-module, rt_lfsr16 (clk, rst_n, en, q[15:0]).

Verification (PRESCALE=1, DELAY_BITS=0, DELAY_MIN=5, CNT_W=8, N_PLAYERS=4)
REQ-037 SHALL cover: start pulse, then btn[2] rises 3 ticks after led_on -> winner=2, time_out=3, win_valid=1, done=1.
REQ-038 SHALL cover: btn[1] rises in WAIT, then btn[1] and btn[3] rise together in RUN -> false_start=4'b0010, winner=3.
REQ-039 SHALL cover: btn[0] and btn[2] rise in the same RUN cycle -> winner=0.
REQ-040 SHALL cover: no press -> after 255 ticks time_out=8'hFF, win_valid=0, done=1.
REQ-041 SHALL cover: all four buttons pressed in WAIT -> DONE, led_on never 1, false_start=4'hF.
REQ-042 SHALL cover: rst_n low during RUN -> same-cycle led_on=0, busy=0; ena=0 for 10 cycles in WAIT -> delay stretched by exactly 10 cycles.
